// File: rtl/reservation_station.sv
// reservation_station: operand-capturing reservation station feeding one functional unit.
// Ports:
//   clock, resetn                 - single clock, asynchronous active-low reset
//   issue_valid/issue_ready       - issue handshake; issue_ready high while an entry is free
//   issue_inst/tag/v1/v2/q1/q2    - instruction, destination tag, operand values and producer tags
//   cdb_valid/cdb_tag/cdb_data    - common data bus broadcast (tag 0 never matches)
//   uf_disponivel                 - functional unit available
//   uf_instructIn                 - one-cycle dispatch strobe
//   uf_instruction/Code/reg1/reg2 - dispatched word, tag and resolved operands (held between strobes)
//   occupancy                     - number of valid entries
//   illegal_op                    - one-cycle pulse after an issue with an unsupported opcode
// Build option: define RS_OLDEST_FIRST_EN to dispatch the oldest ready entry instead of the lowest index.
module reservation_station #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 3
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [15:0]     issue_inst,
    input  logic [TAGW-1:0] issue_tag,
    input  logic [15:0]     issue_v1,
    input  logic [15:0]     issue_v2,
    input  logic [TAGW-1:0] issue_q1,
    input  logic [TAGW-1:0] issue_q2,
    input  logic            cdb_valid,
    input  logic [TAGW-1:0] cdb_tag,
    input  logic [15:0]     cdb_data,
    input  logic            uf_disponivel,
    output logic            uf_instructIn,
    output logic [15:0]     uf_instruction,
    output logic [TAGW-1:0] uf_instructionCode,
    output logic [15:0]     uf_reg1,
    output logic [15:0]     uf_reg2,
    output logic [3:0]      occupancy,
    output logic            illegal_op
);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d, rdy;
    logic [15:0]      inst_q [DEPTH], inst_d [DEPTH];
    logic [15:0]      v1_q   [DEPTH], v1_d   [DEPTH];
    logic [15:0]      v2_q   [DEPTH], v2_d   [DEPTH];
    logic [TAGW-1:0]  tag_q  [DEPTH], tag_d  [DEPTH];
    logic [TAGW-1:0]  q1_q   [DEPTH], q1_d   [DEPTH];
    logic [TAGW-1:0]  q2_q   [DEPTH], q2_d   [DEPTH];
`ifdef RS_OLDEST_FIRST_EN
    logic [2:0]       rank_q [DEPTH], rank_d [DEPTH];
    logic             found;
`endif
    logic [IW-1:0]    free_idx, sel_idx;
    logic [3:0]       occ;
    logic             fire, legal, dispatch, cdb_hit;
    logic             strobe_q, illegal_q;
    logic [15:0]      ins_q, r1_q, r2_q;
    logic [TAGW-1:0]  code_q;

    assign issue_ready = ~&valid_q;
    // add/sub/ld/sd/mul are exactly opcodes 0..4
    assign legal    = issue_inst[3:0] <= 4'd4;
    assign fire     = issue_valid & issue_ready;
    assign cdb_hit  = cdb_valid & (cdb_tag != '0);
    // never dispatch in the cycle right after a strobe: the unit's busy flag lags one edge
    assign dispatch = (|rdy) & uf_disponivel & ~strobe_q;

    always_comb begin
        occ      = '0;
        free_idx = '0;
        rdy      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            occ    = occ + {3'b0, valid_q[i]};
            rdy[i] = valid_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
            if (!valid_q[i]) free_idx = IW'(i);
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // rank 0 is the oldest valid entry; pick the smallest rank among ready entries
    always_comb begin
        sel_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i] && (!found || rank_q[i] < rank_q[sel_idx])) begin
                sel_idx = IW'(i);
                found   = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy[i]) sel_idx = IW'(i);
        end
    end
`endif

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        tag_d   = tag_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        q1_d    = q1_q;
        q2_d    = q2_q;
`ifdef RS_OLDEST_FIRST_EN
        rank_d  = rank_q;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && cdb_hit && q1_q[i] == cdb_tag) begin
                v1_d[i] = cdb_data;
                q1_d[i] = '0;
            end
            if (valid_q[i] && cdb_hit && q2_q[i] == cdb_tag) begin
                v2_d[i] = cdb_data;
                q2_d[i] = '0;
            end
`ifdef RS_OLDEST_FIRST_EN
            // entries younger than the departing one move up a rank
            if (dispatch && rank_q[i] > rank_q[sel_idx]) rank_d[i] = rank_q[i] - 3'd1;
`endif
        end
        if (dispatch) valid_d[sel_idx] = 1'b0;
        if (fire && legal) begin
            valid_d[free_idx] = 1'b1;
            inst_d[free_idx]  = issue_inst;
            tag_d[free_idx]   = issue_tag;
            // same-edge broadcast is captured directly so the operand is not lost
            v1_d[free_idx]    = (cdb_hit && issue_q1 == cdb_tag) ? cdb_data : issue_v1;
            q1_d[free_idx]    = (cdb_hit && issue_q1 == cdb_tag) ? '0 : issue_q1;
            v2_d[free_idx]    = (cdb_hit && issue_q2 == cdb_tag) ? cdb_data : issue_v2;
            q2_d[free_idx]    = (cdb_hit && issue_q2 == cdb_tag) ? '0 : issue_q2;
`ifdef RS_OLDEST_FIRST_EN
            rank_d[free_idx]  = 3'(occ - {3'b0, dispatch});
`endif
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q   <= '0;
            strobe_q  <= 1'b0;
            illegal_q <= 1'b0;
            ins_q     <= '0;
            code_q    <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            strobe_q  <= dispatch;
            illegal_q <= fire & ~legal;
            if (dispatch) begin
                ins_q  <= inst_q[sel_idx];
                code_q <= tag_q[sel_idx];
                r1_q   <= v1_q[sel_idx];
                r2_q   <= v2_q[sel_idx];
            end
        end
    end

    // payload is only meaningful under valid_q, so it needs no reset
    always_ff @(posedge clock) begin
        inst_q <= inst_d;
        tag_q  <= tag_d;
        v1_q   <= v1_d;
        v2_q   <= v2_d;
        q1_q   <= q1_d;
        q2_q   <= q2_d;
`ifdef RS_OLDEST_FIRST_EN
        rank_q <= rank_d;
`endif
    end

    assign uf_instructIn      = strobe_q;
    assign uf_instruction     = ins_q;
    assign uf_instructionCode = code_q;
    assign uf_reg1            = r1_q;
    assign uf_reg2            = r2_q;
    assign occupancy          = occ;
    assign illegal_op         = illegal_q;
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scoreboard bench for reservation_station.
module tb_reservation_station;
    localparam int TAGW = 3;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [15:0]     issue_inst = '0;
    logic [TAGW-1:0] issue_tag = '0;
    logic [15:0]     issue_v1 = '0;
    logic [15:0]     issue_v2 = '0;
    logic [TAGW-1:0] issue_q1 = '0;
    logic [TAGW-1:0] issue_q2 = '0;
    logic            cdb_valid = 1'b0;
    logic [TAGW-1:0] cdb_tag = '0;
    logic [15:0]     cdb_data = '0;
    logic            uf_disponivel = 1'b0;
    logic            uf_instructIn;
    logic [15:0]     uf_instruction;
    logic [TAGW-1:0] uf_instructionCode;
    logic [15:0]     uf_reg1;
    logic [15:0]     uf_reg2;
    logic [3:0]      occupancy;
    logic            illegal_op;

    reservation_station #(.DEPTH(4), .TAGW(TAGW)) dut (
        .clock(clock), .resetn(resetn),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_inst(issue_inst),
        .issue_tag(issue_tag), .issue_v1(issue_v1), .issue_v2(issue_v2),
        .issue_q1(issue_q1), .issue_q2(issue_q2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .uf_disponivel(uf_disponivel), .uf_instructIn(uf_instructIn),
        .uf_instruction(uf_instruction), .uf_instructionCode(uf_instructionCode),
        .uf_reg1(uf_reg1), .uf_reg2(uf_reg2), .occupancy(occupancy), .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0]     inst;
        logic [TAGW-1:0] tag;
        logic [15:0]     r1;
        logic [15:0]     r2;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic prev_strobe;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // advance one edge, sample 1 time unit later, and check any dispatch against the scoreboard
    task automatic step();
        exp_t e;
        prev_strobe = uf_instructIn;
        @(posedge clock);
        #1;
        chk("no_back_to_back", 32'(prev_strobe & uf_instructIn), 32'd0);
        if (uf_instructIn) begin
            chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_inst", 32'(uf_instruction), 32'(e.inst));
                chk("sb_code", 32'(uf_instructionCode), 32'(e.tag));
                chk("sb_reg1", 32'(uf_reg1), 32'(e.r1));
                chk("sb_reg2", 32'(uf_reg2), 32'(e.r2));
            end
        end
    endtask

    task automatic issue(input logic [15:0] inst, input logic [TAGW-1:0] tag,
                         input logic [15:0] v1, input logic [15:0] v2,
                         input logic [TAGW-1:0] q1, input logic [TAGW-1:0] q2,
                         input logic [15:0] r1, input logic [15:0] r2, input bit take);
        issue_valid = 1'b1;
        issue_inst  = inst;
        issue_tag   = tag;
        issue_v1    = v1;
        issue_v2    = v2;
        issue_q1    = q1;
        issue_q2    = q2;
        if (take) sb.push_back('{inst: inst, tag: tag, r1: r1, r2: r2});
        step();
        issue_valid = 1'b0;
    endtask

    initial begin
        int n;
        step();
        step();
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("rst_strobe", 32'(uf_instructIn), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        chk("rst_inst", 32'(uf_instruction), 32'd0);
        chk("rst_code", 32'(uf_instructionCode), 32'd0);
        chk("rst_reg1", 32'(uf_reg1), 32'd0);
        chk("rst_reg2", 32'(uf_reg2), 32'd0);
        resetn = 1'b1;
        uf_disponivel = 1'b1;

        // add, operands ready: strobe after E+1
        issue(16'h1230, 3'd1, 16'd5, 16'd3, 3'd0, 3'd0, 16'd5, 16'd3, 1'b1);
        chk("add_strobe_E", 32'(uf_instructIn), 32'd0);
        chk("add_occ", 32'(occupancy), 32'd1);
        step();
        chk("add_strobe_E1", 32'(uf_instructIn), 32'd1);
        chk("add_reg1", 32'(uf_reg1), 32'd5);
        chk("add_reg2", 32'(uf_reg2), 32'd3);
        chk("add_code", 32'(uf_instructionCode), 32'd1);
        chk("add_occ_after", 32'(occupancy), 32'd0);
        step();
        chk("add_strobe_drop", 32'(uf_instructIn), 32'd0);
        chk("add_hold_reg1", 32'(uf_reg1), 32'd5);

        // sub waiting on tag 4, resolved by CDB two cycles later
        issue(16'h4561, 3'd2, 16'd8, 16'd0, 3'd0, 3'd4, 16'd8, 16'd9, 1'b1);
        chk("sub_strobe_E", 32'(uf_instructIn), 32'd0);
        step();
        chk("sub_strobe_E1", 32'(uf_instructIn), 32'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 3'd4;
        cdb_data  = 16'd9;
        step();
        cdb_valid = 1'b0;
        chk("sub_strobe_cdb", 32'(uf_instructIn), 32'd0);
        chk("sub_occ", 32'(occupancy), 32'd1);
        step();
        chk("sub_strobe", 32'(uf_instructIn), 32'd1);
        chk("sub_reg1", 32'(uf_reg1), 32'd8);
        chk("sub_reg2", 32'(uf_reg2), 32'd9);

        // mul whose producer broadcasts on the issue edge
        cdb_valid = 1'b1;
        cdb_tag   = 3'd3;
        cdb_data  = 16'd7;
        issue(16'h7894, 3'd3, 16'hdead, 16'd2, 3'd3, 3'd0, 16'd7, 16'd2, 1'b1);
        cdb_valid = 1'b0;
        chk("mul_strobe_E", 32'(uf_instructIn), 32'd0);
        step();
        chk("mul_strobe_E1", 32'(uf_instructIn), 32'd1);
        chk("mul_reg1", 32'(uf_reg1), 32'd7);
        step();

        // issue and dispatch on the same edge, then enforced strobe gap
        uf_disponivel = 1'b0;
        issue(16'h0aa0, 3'd5, 16'd1, 16'd1, 3'd0, 3'd0, 16'd1, 16'd1, 1'b1);
        chk("sim_occ_a", 32'(occupancy), 32'd1);
        uf_disponivel = 1'b1;
        issue(16'h0bb1, 3'd6, 16'd2, 16'd2, 3'd0, 3'd0, 16'd2, 16'd2, 1'b1);
        chk("sim_strobe", 32'(uf_instructIn), 32'd1);
        chk("sim_occ", 32'(occupancy), 32'd1);
        chk("sim_code_a", 32'(uf_instructionCode), 32'd5);
        step();
        chk("sim_gap", 32'(uf_instructIn), 32'd0);
        step();
        chk("sim_strobe_b", 32'(uf_instructIn), 32'd1);
        chk("sim_code_b", 32'(uf_instructionCode), 32'd6);
        chk("sim_occ_b", 32'(occupancy), 32'd0);
        step();

        // fill while the unit is busy, then drain
        uf_disponivel = 1'b0;
        for (int k = 0; k < 4; k++)
            issue({12'(k + 1), 4'(k)}, 3'(k + 1), 16'(10 + k), 16'(20 + k), 3'd0, 3'd0,
                  16'(10 + k), 16'(20 + k), 1'b1);
        chk("full_ready", 32'(issue_ready), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd4);
        issue(16'h0dd0, 3'd7, 16'd0, 16'd0, 3'd0, 3'd0, 16'd0, 16'd0, 1'b0);
        chk("full_ignored", 32'(occupancy), 32'd4);
        uf_disponivel = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (uf_instructIn) n++;
        end
        chk("drain_count", 32'(n), 32'd4);
        chk("drain_occ", 32'(occupancy), 32'd0);
        chk("drain_sb", 32'(sb.size()), 32'd0);

        // illegal opcode
        uf_disponivel = 1'b0;
        issue(16'h555f, 3'd1, 16'd0, 16'd0, 3'd0, 3'd0, 16'd0, 16'd0, 1'b0);
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        chk("ill_occ", 32'(occupancy), 32'd0);
        step();
        chk("ill_drop", 32'(illegal_op), 32'd0);
        issue(16'h0010, 3'd1, 16'd1, 16'd1, 3'd0, 3'd0, 16'd1, 16'd1, 1'b1);
        issue(16'h000f, 3'd2, 16'd0, 16'd0, 3'd0, 3'd0, 16'd0, 16'd0, 1'b0);
        chk("ill_pulse2", 32'(illegal_op), 32'd1);
        chk("ill_occ2", 32'(occupancy), 32'd1);
        issue(16'h0021, 3'd2, 16'd2, 16'd2, 3'd0, 3'd0, 16'd2, 16'd2, 1'b1);
        issue(16'h0032, 3'd3, 16'd3, 16'd3, 3'd0, 3'd0, 16'd3, 16'd3, 1'b1);
        chk("pend_occ", 32'(occupancy), 32'd3);

        // asynchronous reset discards pending entries
        resetn = 1'b0;
        #1;
        chk("mrst_occ", 32'(occupancy), 32'd0);
        chk("mrst_strobe", 32'(uf_instructIn), 32'd0);
        chk("mrst_ready", 32'(issue_ready), 32'd1);
        sb.delete();
        uf_disponivel = 1'b1;
        step();
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_no_strobe", 32'(uf_instructIn), 32'd0);
        end
        chk("post_rst_occ", 32'(occupancy), 32'd0);
        issue(16'h0994, 3'd4, 16'd44, 16'd55, 3'd0, 3'd0, 16'd44, 16'd55, 1'b1);
        step();
        chk("post_rst_strobe", 32'(uf_instructIn), 32'd1);
        step();
        chk("final_sb", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
